// File: rtl/gpr_dbg_ctrl.sv
// Debug access sequencer for the GPR file JTAG port: halts the core, performs one
// register read/write, returns the response. Optional halt timeout: GPR_DBG_TIMEOUT_EN.
module gpr_dbg_ctrl #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  input  logic              dbg_rready_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_err_o,
  input  logic              dbg_hold_i,
  output logic              halt_req_o,
  input  logic              halted_i,
  input  logic              reg_wen_i,
  output logic              gpr_jtag_en_o,
  output logic [ADDR_W-1:0] gpr_jtag_addr_o,
  output logic [DATA_W-1:0] gpr_jtag_data_o,
  input  logic [DATA_W-1:0] gpr_jtag_data_i
);

  typedef enum logic [1:0] {IDLE, HALT, ACCESS, RESP} state_t;

  state_t            state;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              zero_path;
  logic              rvalid;
  logic              halt_req;
  logic [DATA_W-1:0] rdata;
  logic              accept;
  logic              handshake;
  logic              expire;

  assign accept    = (state == IDLE) && dbg_req_i && !rst_i;
  assign handshake = (state == RESP) && dbg_rready_i;

  // Reset gates the strobes so an access aborted mid-cycle never reaches the register file
  assign dbg_gnt_o       = accept;
  assign gpr_jtag_en_o   = (state == ACCESS) && we && !reg_wen_i && !rst_i;
  assign gpr_jtag_addr_o = (state == ACCESS) ? addr : '0;
  assign gpr_jtag_data_o = ((state == ACCESS) && we) ? wdata : '0;

  assign dbg_rvalid_o = rvalid;
  assign dbg_rdata_o  = rdata;
  assign halt_req_o   = halt_req;

`ifdef GPR_DBG_TIMEOUT_EN
  localparam int CNT_W = ($clog2(HALT_TIMEOUT + 1) > 8) ? $clog2(HALT_TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] cnt;
  logic             err;

  assign expire    = (state == HALT) && !halted_i && (cnt + CNT_W'(1) == CNT_W'(HALT_TIMEOUT));
  assign dbg_err_o = err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (accept)
        cnt <= '0;
      else if ((state == HALT) && !halted_i)
        cnt <= cnt + CNT_W'(1);
      if (expire)
        err <= 1'b1;
      else if (handshake)
        err <= 1'b0;
    end
  end
`else
  assign expire    = 1'b0;
  assign dbg_err_o = 1'b0;
`endif

  // x0 accesses skip the halt entirely, so their RESP leaves halt_req following dbg_hold_i
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      we        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      zero_path <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      halt_req  <= 1'b0;
    end else begin
      halt_req <= dbg_hold_i;
      case (state)
        IDLE: begin
          if (dbg_req_i) begin
            we    <= dbg_we_i;
            addr  <= dbg_addr_i;
            wdata <= dbg_wdata_i;
            if (dbg_addr_i == '0) begin
              state     <= RESP;
              rvalid    <= 1'b1;
              rdata     <= '0;
              zero_path <= 1'b1;
            end else begin
              state     <= HALT;
              halt_req  <= 1'b1;
              zero_path <= 1'b0;
            end
          end
        end
        HALT: begin
          halt_req <= 1'b1;
          if (halted_i) begin
            state <= ACCESS;
          end else if (expire) begin
            state  <= RESP;
            rvalid <= 1'b1;
            rdata  <= '0;
          end
        end
        ACCESS: begin
          halt_req <= 1'b1;
          if (!reg_wen_i) begin
            state  <= RESP;
            rvalid <= 1'b1;
            rdata  <= we ? '0 : gpr_jtag_data_i;
          end
        end
        RESP: begin
          if (handshake) begin
            state  <= IDLE;
            rvalid <= 1'b0;
            rdata  <= '0;
          end else begin
            halt_req <= dbg_hold_i || !zero_path;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_dbg_ctrl.sv
// Self-checking bench for gpr_dbg_ctrl: directed vector table, reset aborts and random
// transactions against a timeline/register-file model. Honours GPR_DBG_TIMEOUT_EN.
module tb_gpr_dbg_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef GPR_DBG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          dbg_req_i;
  logic          dbg_we_i;
  logic [AW-1:0] dbg_addr_i;
  logic [DW-1:0] dbg_wdata_i;
  logic          dbg_gnt_o;
  logic          dbg_rvalid_o;
  logic          dbg_rready_i;
  logic [DW-1:0] dbg_rdata_o;
  logic          dbg_err_o;
  logic          dbg_hold_i;
  logic          halt_req_o;
  logic          halted_i;
  logic          reg_wen_i;
  logic          gpr_jtag_en_o;
  logic [AW-1:0] gpr_jtag_addr_o;
  logic [DW-1:0] gpr_jtag_data_o;
  logic [DW-1:0] gpr_jtag_data_i;

  gpr_dbg_ctrl #(.ADDR_W(AW), .DATA_W(DW), .HALT_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o),
    .dbg_rready_i(dbg_rready_i), .dbg_rdata_o(dbg_rdata_o), .dbg_err_o(dbg_err_o),
    .dbg_hold_i(dbg_hold_i), .halt_req_o(halt_req_o), .halted_i(halted_i),
    .reg_wen_i(reg_wen_i), .gpr_jtag_en_o(gpr_jtag_en_o),
    .gpr_jtag_addr_o(gpr_jtag_addr_o), .gpr_jtag_data_o(gpr_jtag_data_o),
    .gpr_jtag_data_i(gpr_jtag_data_i)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  logic prev_hold = 1'b0;
  logic preload = 1'b1;
  logic [DW-1:0] mem [32];
  logic [DW-1:0] exp_reg [32];

  function automatic logic [DW-1:0] seedVal(input int i);
    if (i == 0) return '0;
    if (i == 7) return 32'h12345678;
    return 32'h5A000000 + 32'(i) * 32'h00010101;
  endfunction

  // Register file stand-in: written only by the DUT's JTAG strobe, read combinationally
  always @(posedge clk_i) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= seedVal(i);
    end else if (gpr_jtag_en_o) begin
      mem[gpr_jtag_addr_o] <= gpr_jtag_data_o;
    end
  end
  assign gpr_jtag_data_i = mem[gpr_jtag_addr_o];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            hw;
    int            wn;
    int            rd;
    logic          hold;
    int            exp_lat;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic req, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic rready, input logic hold, input logic halted,
                               input logic wen);
    prev_hold    = rst_i ? 1'b0 : dbg_hold_i;
    rst_i        = rst;
    dbg_req_i    = req;
    dbg_we_i     = we;
    dbg_addr_i   = addr;
    dbg_wdata_i  = wdata;
    dbg_rready_i = rready;
    dbg_hold_i   = hold;
    halted_i     = halted;
    reg_wen_i    = wen;
  endtask

  task automatic checkOutput(input string name, input int t, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0d: got %h, expected %h", name, t, act, exp);
    end
  endtask

  // One request from IDLE to one idle cycle past the handshake. Cycle 0 carries the
  // request; halted_i rises at cycle 1+hw; reg_wen_i blocks the first wn ACCESS cycles;
  // dbg_rready_i arrives rd cycles into RESP.
  task automatic runTxn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int hw, input int wn, input int rd, input logic hold,
                        input bit noise, output int lat, output logic [DW-1:0] rdat,
                        output logic errv);
    bit zero, tout, in_acc, rv;
    int acc_s, acc_e, resp, hs;
    logic [DW-1:0] exp_data;
    logic ph;
    logic req_v, rready_v, wen_v;
    zero  = (addr == '0);
    tout  = !zero && TO_EN && (hw >= TO);
    acc_s = -1;
    acc_e = -1;
    if (zero) resp = 1;
    else if (tout) resp = 1 + TO;
    else begin
      acc_s = 2 + hw;
      acc_e = acc_s + wn;
      resp  = acc_e + 1;
    end
    hs       = resp + rd;
    exp_data = (zero || tout || we) ? '0 : exp_reg[addr];
    lat  = -1;
    rdat = '0;
    errv = 1'b0;
    ph   = 1'b0;
    for (int t = 0; t <= hs + 1; t++) begin
      in_acc   = (acc_s >= 0) && (t >= acc_s) && (t <= acc_e);
      req_v    = (t == 0) || (noise && (t <= hs) && ($urandom_range(0, 1) == 1));
      rready_v = (t == hs) || (noise && (t < resp) && ($urandom_range(0, 1) == 1));
      wen_v    = in_acc ? (t < acc_e) : (noise && ($urandom_range(0, 1) == 1));
      if (t == 0)
        applyStimulus(1'b0, 1'b1, we, addr, wdata, rready_v, hold, 1'b0, wen_v);
      else
        applyStimulus(1'b0, req_v, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)),
                      $urandom, rready_v, hold, t >= 1 + hw, wen_v);
      if (t == 0) ph = prev_hold;
      #1;
      rv = (t >= resp) && (t <= hs);
      checkOutput("gnt", t, dbg_gnt_o, t == 0);
      checkOutput("halt_req", t, halt_req_o, (t == 0) ? ph : ((!zero && t <= hs) ? 1'b1 : hold));
      checkOutput("jtag_en", t, gpr_jtag_en_o, we && in_acc && (t == acc_e));
      checkOutput("jtag_addr", t, gpr_jtag_addr_o, in_acc ? addr : '0);
      checkOutput("jtag_data", t, gpr_jtag_data_o, (in_acc && we) ? wdata : '0);
      checkOutput("rvalid", t, dbg_rvalid_o, rv);
      checkOutput("rdata", t, dbg_rdata_o, rv ? exp_data : '0);
      checkOutput("err", t, dbg_err_o, rv && tout);
      if (t == resp) begin
        lat  = t;
        rdat = dbg_rdata_o;
        errv = dbg_err_o;
      end
      nextCycle();
    end
    if (we && !zero && !tout) exp_reg[addr] = wdata;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [DW-1:0] rdat;
    logic errv;
    logic [AW-1:0] r_addr;

    for (int i = 0; i < 32; i++) exp_reg[i] = seedVal(i);

    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 2, 0, 0, 1'b0, 5, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 5'd7, 32'h0,        0, 0, 0, 1'b0, 3, 32'h12345678, 1'b0};
    vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 1'b0, 1, 32'h0, 1'b0};
    vecs[3] = '{1'b1, 5'd9, 32'h0BADF00D, 0, 3, 4, 1'b0, 6, 32'h0, 1'b0};
    vecs[4] = '{1'b0, 5'd9, 32'h0,        1, 3, 4, 1'b0, 7, 32'h0BADF00D, 1'b0};
    vecs[5] = '{1'b0, 5'd7, 32'h0,        0, 0, 0, 1'b1, 3, 32'h12345678, 1'b0};
    vecs[6] = '{1'b0, 5'd5, 32'h0,        0, 0, 1, 1'b1, 3, 32'hDEADBEEF, 1'b0};
    vecs[7] = '{1'b0, 5'd0, 32'h0,        0, 0, 0, 1'b0, 1, 32'h0, 1'b0};
    vecs[8] = '{1'b1, 5'd3, 32'h33333333, 5, 0, 0, 1'b0, TO_EN ? 5 : 8, 32'h0, TO_EN};
    vecs[9] = '{1'b0, 5'd3, 32'h0,        0, 0, 0, 1'b0, 3,
                TO_EN ? 32'h5A030303 : 32'h33333333, 1'b0};

    applyStimulus(1'b1, 1'b1, 1'b1, 5'd5, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("reset_gnt", 0, dbg_gnt_o, 1'b0);
    checkOutput("reset_halt_req", 0, halt_req_o, 1'b0);
    checkOutput("reset_rvalid", 0, dbg_rvalid_o, 1'b0);
    checkOutput("reset_rdata", 0, dbg_rdata_o, '0);
    checkOutput("reset_err", 0, dbg_err_o, 1'b0);
    checkOutput("reset_jtag_en", 0, gpr_jtag_en_o, 1'b0);
    checkOutput("reset_jtag_addr", 0, gpr_jtag_addr_o, '0);
    checkOutput("reset_jtag_data", 0, gpr_jtag_data_o, '0);
    preload = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();

    for (int i = 0; i < 10; i++) begin
      runTxn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hw, vecs[i].wn, vecs[i].rd,
             vecs[i].hold, 1'b0, lat, rdat, errv);
      checkOutput("tbl_latency", i, lat, vecs[i].exp_lat);
      checkOutput("tbl_rdata", i, rdat, vecs[i].exp_rdata);
      checkOutput("tbl_err", i, errv, vecs[i].exp_err);
    end

    // Reset in HALT (rc=1) and in a write ACCESS (rc=2) must abort with no write or response
    for (int rc = 1; rc <= 2; rc++) begin
      for (int t = 0; t <= rc + 3; t++) begin
        applyStimulus(t == rc, t == 0, 1'b1, 5'd11, 32'hC0FFEE00 + rc, 1'b0, 1'b0, t >= 1, 1'b0);
        #1;
        if (t == 0) checkOutput("rst_gnt", t, dbg_gnt_o, 1'b1);
        if (t == rc) checkOutput("rst_jtag_en", t, gpr_jtag_en_o, 1'b0);
        if (t > rc) begin
          checkOutput("rst_halt_req", t, halt_req_o, 1'b0);
          checkOutput("rst_rvalid", t, dbg_rvalid_o, 1'b0);
          checkOutput("rst_gnt_after", t, dbg_gnt_o, 1'b0);
          checkOutput("rst_en_after", t, gpr_jtag_en_o, 1'b0);
          checkOutput("rst_addr_after", t, gpr_jtag_addr_o, '0);
          checkOutput("rst_rdata_after", t, dbg_rdata_o, '0);
        end
        nextCycle();
      end
      checkOutput("rst_no_write", rc, mem[11], exp_reg[11]);
    end

    for (int n = 0; n < 80; n++) begin
      r_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
      runTxn($urandom_range(0, 1) == 1, r_addr, $urandom, int'($urandom_range(0, 5)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, 1'b1, lat, rdat, errv);
    end

    for (int i = 1; i < 32; i++) checkOutput("final_regfile", i, mem[i], exp_reg[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
